conv_operand_feeder: RTL and testbench
======================================

Name: conv_operand_feeder

Overview:
- Synthesizable operand source for the CONV engine; replaces the behavioural IFM/weight feeders.
- Answers CONV's ifm_read / wgt_read strobes by generating addresses into two synchronous-read SRAMs.
- Returns each operand one cycle after its strobe, with optional on-the-fly zero-padding insertion.
- Supports multi-pass IFM re-streaming, continuous weight wrap, and done/overrun status reporting.

Parameters:
- IFM_WIDTH, 8, IFM pixel width.
- WEIGHT_WIDTH, 8, weight width.
- IFM_SIZE, 64, unpadded IFM height = width.
- KERNEL_SIZE, 3, kernel height = width.
- PAD, 0, zero border per side (0..KERNEL_SIZE-1). Only honoured with CONV_PAD_INSERT_EN.
- CI, 3, input channels.
- CO, 8, output channels.
- IFM_PASSES, 1, full IFM streams per start_conv (1..255).
- IFM_AW, $clog2(CI*IFM_SIZE*IFM_SIZE), IFM memory address width.
- WGT_AW, $clog2(CO*CI*KERNEL_SIZE*KERNEL_SIZE), weight memory address width.

Ports:
- clk2, in, 1, operand clock.
- rst_n, in, 1, asynchronous active-low reset.
- start_conv, in, 1, one-cycle start pulse; restarts both streams.
- ifm_read, in, 1, request next IFM element.
- wgt_read, in, 1, request next weight.
- ifm_mem_rd, out, 1, IFM SRAM read enable.
- ifm_mem_addr, out, IFM_AW, IFM SRAM address.
- ifm_mem_rdata, in, IFM_WIDTH, IFM SRAM data; valid the cycle after ifm_mem_rd.
- wgt_mem_rd, out, 1, weight SRAM read enable.
- wgt_mem_addr, out, WGT_AW, weight SRAM address.
- wgt_mem_rdata, in, WEIGHT_WIDTH, weight SRAM data; 1-cycle latency.
- ifm, out, IFM_WIDTH, IFM operand to CONV.
- ifm_valid, out, 1, ifm holds a requested element.
- wgt, out, WEIGHT_WIDTH, weight operand to CONV.
- wgt_valid, out, 1, wgt holds a requested element.
- wgt_wrap, out, 1, pulse with the last weight of each CO*CI*K*K sweep.
- ifm_done, out, 1, pulse with the last element of the final pass.
- busy, out, 1, IFM stream is in ACTIVE.
- overrun, out, 1, sticky: ifm_read seen while IFM stream is IDLE or DONE.

Behaviour:
- Interface: clock clk2; reset rst_n, asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - Both FSMs in IDLE.
  - All counters 0.
- IFM FSM states: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE on start_conv.
  - ACTIVE -> DONE on the read that consumes the last element of pass IFM_PASSES.
  - DONE -> ACTIVE on start_conv.
  - start_conv in any state: clears counters, clears overrun, enters ACTIVE.
  - A read coinciding with start_conv is ignored; no memory access and no valid.
- IFM scan order:
  - Padded frame side P = IFM_SIZE + 2*PAD.
  - Order: channel outer, row, column inner. Total CI*P*P elements per pass.
- Element fetch (ifm_read in ACTIVE, cycle n):
  - Interior (row, col both in [PAD, PAD+IFM_SIZE-1]): ifm_mem_rd=1 in cycle n, combinational from ifm_read.
  - ifm_mem_addr = ch*IFM_SIZE*IFM_SIZE + (row-PAD)*IFM_SIZE + (col-PAD).
  - Border: ifm_mem_rd=0.
  - Cycle n+1: ifm_valid=1; ifm = ifm_mem_rdata for interior, 0 for border.
- Output hold: ifm = 0 whenever ifm_valid=0. Back-to-back reads give one element per cycle.
- Pass wrap: after element CI*P*P-1, counters wrap to 0 and the pass count increments.
- ifm_done asserts in the same cycle as ifm_valid for the final element.
- Weights:
  - Linear address 0..CO*CI*K*K-1 with identical 1-cycle timing to IFM; wgt = 0 when wgt_valid=0.
  - Wraps to 0 after the last address.
  - wgt_wrap pulses alongside that element's wgt_valid.
  - The weight stream never enters DONE; start_conv resets its address to 0.
- Reads after DONE (ifm_read in IDLE or DONE): ignored; ifm_mem_rd=0; overrun set.
- Simultaneous ifm_read and wgt_read: independent, both served.
- Reset mid-operation: immediate return to reset values; in-flight data discarded, valids drop.
- Arithmetic: counters sized with $clog2 of their maxima; address multiplies are constant-parameter only.

Optional Feature:
- CONV_PAD_INSERT_EN defined:
  - PAD honoured; border zeros generated with no memory access.
  - Row/column counters range 0..P-1.
- Not defined:
  - PAD is ignored and treated as 0; border logic is removed.
  - Address equals a flat element counter.
  - An initial-block assertion fires if PAD != 0.

Decomposition:
- Package conv_feed_pkg:
  - FSM state typedef (IDLE/ACTIVE/DONE).
  - Width helper functions.
  - Constants: padded size, frame length, weight length.
- Sub-module conv_feed_ctr: a wrapping counter with enable, synchronous clear, configurable max, and a wrap pulse.
  - Instantiated for column, row, channel, pass and weight address.

Test Plan:
- CI=3, IFM_SIZE=64, PAD=0: start, then 12288 back-to-back reads.
  - Expect ifm = mem[0..12287] in order, each one cycle after its read.
  - Expect ifm_done with element 12287; busy drops the next cycle.
- CONV_PAD_INSERT_EN, IFM_SIZE=4, PAD=1, CI=1:
  - Reads 0..6 return 0 with ifm_mem_rd=0.
  - Read 7 returns mem[0].
  - 36 reads per pass in total.
- Weights, CO=8, CI=3, K=3:
  - 216 reads give mem[0..215]; wgt_wrap with element 215.
  - Read 217 returns mem[0].
- IFM_PASSES=2: 24576 reads; ifm_done only once, after the second pass.
  - One more read: overrun=1, no memory access, ifm_valid=0.
- start_conv asserted with ifm_read at element 500: the read is ignored.
  - The next read returns mem[0] and overrun is cleared.
- rst_n low for 1 cycle mid-stream: all outputs 0 immediately.
  - After start_conv, streaming resumes from address 0.

Source files
------------

// File: rtl/conv_feed_pkg.sv
// Shared types, width helpers and default geometry for the CONV operand feeder.
package conv_feed_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } feed_state_e;

    // Counter width able to hold 0..n-1 (never narrower than one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned padded_size(input int unsigned size, input int unsigned pad);
        return size + 2 * pad;
    endfunction

    function automatic int unsigned frame_len(input int unsigned ci, input int unsigned p);
        return ci * p * p;
    endfunction

    function automatic int unsigned wgt_len(input int unsigned co, input int unsigned ci,
                                            input int unsigned k);
        return co * ci * k * k;
    endfunction

    localparam int unsigned DEF_PADDED_SIZE = padded_size(64, 0);
    localparam int unsigned DEF_FRAME_LEN   = frame_len(3, DEF_PADDED_SIZE);
    localparam int unsigned DEF_WGT_LEN     = wgt_len(8, 3, 3);

endpackage

// File: rtl/conv_feed_ctr.sv
// Wrapping counter 0..MAX with enable, synchronous clear (priority) and a wrap strobe.
module conv_feed_ctr #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 9
) (
    input  logic         clk2,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_c = en && (cnt_q == W'(MAX));
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap_c ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/conv_operand_feeder.sv
// IFM / weight operand source for the CONV engine, fed from two 1-cycle-latency SRAMs.
// Zero-border insertion is built only when CONV_PAD_INSERT_EN is defined.
module conv_operand_feeder
    import conv_feed_pkg::*;
#(
    parameter int unsigned IFM_WIDTH    = 8,
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned IFM_SIZE     = 64,
    parameter int unsigned KERNEL_SIZE  = 3,
    parameter int unsigned PAD          = 0,
    parameter int unsigned CI           = 3,
    parameter int unsigned CO           = 8,
    parameter int unsigned IFM_PASSES   = 1,
    parameter int unsigned IFM_AW       = $clog2(CI*IFM_SIZE*IFM_SIZE),
    parameter int unsigned WGT_AW       = $clog2(CO*CI*KERNEL_SIZE*KERNEL_SIZE)
) (
    input  logic                    clk2,
    input  logic                    rst_n,
    input  logic                    start_conv,
    input  logic                    ifm_read,
    input  logic                    wgt_read,
    output logic                    ifm_mem_rd,
    output logic [IFM_AW-1:0]       ifm_mem_addr,
    input  logic [IFM_WIDTH-1:0]    ifm_mem_rdata,
    output logic                    wgt_mem_rd,
    output logic [WGT_AW-1:0]       wgt_mem_addr,
    input  logic [WEIGHT_WIDTH-1:0] wgt_mem_rdata,
    output logic [IFM_WIDTH-1:0]    ifm,
    output logic                    ifm_valid,
    output logic [WEIGHT_WIDTH-1:0] wgt,
    output logic                    wgt_valid,
    output logic                    wgt_wrap,
    output logic                    ifm_done,
    output logic                    busy,
    output logic                    overrun
);

`ifdef CONV_PAD_INSERT_EN
    localparam int unsigned P_EFF = padded_size(IFM_SIZE, PAD);
`else
    localparam int unsigned P_EFF = IFM_SIZE;
`endif
    localparam int unsigned FRAME = frame_len(CI, P_EFF);
    localparam int unsigned WLEN  = wgt_len(CO, CI, KERNEL_SIZE);
    localparam int unsigned PW    = cnt_w(IFM_PASSES);
    localparam int unsigned WW    = cnt_w(WLEN);

    feed_state_e ifm_st_q, ifm_st_d;
    feed_state_e wgt_st_q, wgt_st_d;
    logic        ovr_q, ovr_d;
    logic        ifm_valid_q, ifm_valid_d;
    logic        ifm_inside_q, ifm_inside_d;
    logic        ifm_done_q, ifm_done_d;
    logic        wgt_valid_q, wgt_valid_d;
    logic        wgt_wrap_q, wgt_wrap_d;

    logic              ifm_fetch_c;
    logic              ifm_inside_c;
    logic              frame_wrap_c;
    logic              last_elem_c;
    logic [IFM_AW-1:0] ifm_addr_c;
    logic [PW-1:0]     pass_cnt;
    logic              wgt_fetch_c;
    logic              wgt_last_c;
    logic [WW-1:0]     wgt_addr;

    // A read sharing a cycle with start_conv is dropped.
    assign ifm_fetch_c = ifm_read && !start_conv && (ifm_st_q == ACTIVE);
    assign wgt_fetch_c = wgt_read && !start_conv && (wgt_st_q == ACTIVE);

`ifdef CONV_PAD_INSERT_EN
    localparam int unsigned SW = cnt_w(P_EFF);
    localparam int unsigned CW = cnt_w(CI);

    logic [SW-1:0] col_cnt, row_cnt;
    logic [CW-1:0] ch_cnt;
    logic          col_wrap_c, row_wrap_c;
    logic [31:0]   col_off_c, row_off_c;

    conv_feed_ctr #(.W(SW), .MAX(P_EFF-1)) u_col (.clk2(clk2), .rst_n(rst_n), .clr(start_conv),
        .en(ifm_fetch_c), .cnt(col_cnt), .wrap_c(col_wrap_c));
    conv_feed_ctr #(.W(SW), .MAX(P_EFF-1)) u_row (.clk2(clk2), .rst_n(rst_n), .clr(start_conv),
        .en(col_wrap_c), .cnt(row_cnt), .wrap_c(row_wrap_c));
    conv_feed_ctr #(.W(CW), .MAX(CI-1)) u_ch (.clk2(clk2), .rst_n(rst_n), .clr(start_conv),
        .en(row_wrap_c), .cnt(ch_cnt), .wrap_c(frame_wrap_c));

    // Offsets wrap to huge values left of the border, so one compare covers both sides.
    assign col_off_c    = 32'(col_cnt) - PAD;
    assign row_off_c    = 32'(row_cnt) - PAD;
    assign ifm_inside_c = (col_off_c < IFM_SIZE) && (row_off_c < IFM_SIZE);
    assign ifm_addr_c   = IFM_AW'(32'(ch_cnt) * (IFM_SIZE * IFM_SIZE) + row_off_c * IFM_SIZE + col_off_c);
`else
    localparam int unsigned EW = cnt_w(FRAME);

    logic [EW-1:0] elem_cnt;

    conv_feed_ctr #(.W(EW), .MAX(FRAME-1)) u_elem (.clk2(clk2), .rst_n(rst_n), .clr(start_conv),
        .en(ifm_fetch_c), .cnt(elem_cnt), .wrap_c(frame_wrap_c));

    assign ifm_inside_c = 1'b1;
    assign ifm_addr_c   = IFM_AW'(elem_cnt);

    if (PAD != 0) begin : g_pad_unsupported
        $error("PAD must be 0 unless CONV_PAD_INSERT_EN is defined");
    end
`endif

    conv_feed_ctr #(.W(PW), .MAX(IFM_PASSES-1)) u_pass (.clk2(clk2), .rst_n(rst_n), .clr(start_conv),
        .en(frame_wrap_c), .cnt(pass_cnt), .wrap_c(last_elem_c));

    conv_feed_ctr #(.W(WW), .MAX(WLEN-1)) u_wgt (.clk2(clk2), .rst_n(rst_n), .clr(start_conv),
        .en(wgt_fetch_c), .cnt(wgt_addr), .wrap_c(wgt_last_c));

    // Next-state and registered-output logic for both streams.
    always_comb begin
        ifm_st_d     = ifm_st_q;
        wgt_st_d     = wgt_st_q;
        ovr_d        = ovr_q;
        ifm_valid_d  = ifm_fetch_c;
        ifm_inside_d = ifm_fetch_c && ifm_inside_c;
        ifm_done_d   = last_elem_c;
        wgt_valid_d  = wgt_fetch_c;
        wgt_wrap_d   = wgt_last_c;
        if (start_conv) begin
            ifm_st_d = ACTIVE;
            wgt_st_d = ACTIVE;
            ovr_d    = 1'b0;
        end else if (ifm_read) begin
            if (ifm_st_q == ACTIVE) begin
                if (last_elem_c) begin
                    ifm_st_d = DONE;
                end
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            ifm_st_q     <= IDLE;
            wgt_st_q     <= IDLE;
            ovr_q        <= 1'b0;
            ifm_valid_q  <= 1'b0;
            ifm_inside_q <= 1'b0;
            ifm_done_q   <= 1'b0;
            wgt_valid_q  <= 1'b0;
            wgt_wrap_q   <= 1'b0;
        end else begin
            ifm_st_q     <= ifm_st_d;
            wgt_st_q     <= wgt_st_d;
            ovr_q        <= ovr_d;
            ifm_valid_q  <= ifm_valid_d;
            ifm_inside_q <= ifm_inside_d;
            ifm_done_q   <= ifm_done_d;
            wgt_valid_q  <= wgt_valid_d;
            wgt_wrap_q   <= wgt_wrap_d;
        end
    end

    assign ifm_mem_rd   = ifm_fetch_c && ifm_inside_c;
    assign ifm_mem_addr = ifm_mem_rd ? ifm_addr_c : '0;
    assign wgt_mem_rd   = wgt_fetch_c;
    assign wgt_mem_addr = wgt_mem_rd ? WGT_AW'(wgt_addr) : '0;

    // SRAM data lands the cycle after the strobe; border slots and idle cycles read as 0.
    assign ifm       = ifm_inside_q ? ifm_mem_rdata : '0;
    assign ifm_valid = ifm_valid_q;
    assign ifm_done  = ifm_done_q;
    assign wgt       = wgt_valid_q ? wgt_mem_rdata : '0;
    assign wgt_valid = wgt_valid_q;
    assign wgt_wrap  = wgt_wrap_q;
    assign busy      = (ifm_st_q == ACTIVE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_conv_operand_feeder.sv
// Scoreboard bench for conv_operand_feeder: random read strobes against a frame-walk reference model.
module tb_conv_operand_feeder;

    localparam int unsigned IFM_WIDTH    = 8;
    localparam int unsigned WEIGHT_WIDTH = 8;
    localparam int unsigned IFM_SIZE     = 16;
    localparam int unsigned KERNEL_SIZE  = 3;
    localparam int unsigned CI           = 3;
    localparam int unsigned CO           = 8;
    localparam int unsigned IFM_PASSES   = 2;
`ifdef CONV_PAD_INSERT_EN
    localparam int unsigned PAD          = 1;
`else
    localparam int unsigned PAD          = 0;
`endif
    localparam int unsigned P      = IFM_SIZE + 2 * PAD;
    localparam int unsigned FRAME  = CI * P * P;
    localparam int unsigned IMEM   = CI * IFM_SIZE * IFM_SIZE;
    localparam int unsigned WLEN   = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned IFM_AW = $clog2(IMEM);
    localparam int unsigned WGT_AW = $clog2(WLEN);

    typedef struct packed { logic [IFM_WIDTH-1:0] d; logic f; } exp_i_t;
    typedef struct packed { logic [WEIGHT_WIDTH-1:0] d; logic f; } exp_w_t;

    logic clk2, rst_n, start_conv, ifm_read, wgt_read;
    logic ifm_mem_rd, wgt_mem_rd;
    logic [IFM_AW-1:0] ifm_mem_addr;
    logic [WGT_AW-1:0] wgt_mem_addr;
    logic [IFM_WIDTH-1:0] ifm_mem_rdata, ifm;
    logic [WEIGHT_WIDTH-1:0] wgt_mem_rdata, wgt;
    logic ifm_valid, wgt_valid, wgt_wrap, ifm_done, busy, overrun;

    logic [IFM_WIDTH-1:0]    ifm_mem [IMEM];
    logic [WEIGHT_WIDTH-1:0] wgt_mem [WLEN];

    exp_i_t ifm_q[$];
    exp_w_t wgt_q[$];

    int n_vec, n_err, n_done;
    bit in_rst;
    // Reference model state
    int m_st;              // 0 idle, 1 active, 2 done
    int unsigned m_e, m_p, w_i;
    bit m_ovr, w_act, ovr_vis, busy_vis;
    bit exp_ifm_rd, exp_wgt_rd;
    logic [IFM_AW-1:0] exp_ifm_addr;
    logic [WGT_AW-1:0] exp_wgt_addr;

    conv_operand_feeder #(
        .IFM_WIDTH(IFM_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH), .IFM_SIZE(IFM_SIZE),
        .KERNEL_SIZE(KERNEL_SIZE), .PAD(PAD), .CI(CI), .CO(CO), .IFM_PASSES(IFM_PASSES),
        .IFM_AW(IFM_AW), .WGT_AW(WGT_AW)
    ) dut (
        .clk2(clk2), .rst_n(rst_n), .start_conv(start_conv), .ifm_read(ifm_read),
        .wgt_read(wgt_read), .ifm_mem_rd(ifm_mem_rd), .ifm_mem_addr(ifm_mem_addr),
        .ifm_mem_rdata(ifm_mem_rdata), .wgt_mem_rd(wgt_mem_rd), .wgt_mem_addr(wgt_mem_addr),
        .wgt_mem_rdata(wgt_mem_rdata), .ifm(ifm), .ifm_valid(ifm_valid), .wgt(wgt),
        .wgt_valid(wgt_valid), .wgt_wrap(wgt_wrap), .ifm_done(ifm_done), .busy(busy),
        .overrun(overrun)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    // Synchronous-read SRAMs; garbage on the bus when not read.
    always @(posedge clk2) begin
        if (ifm_mem_rd) ifm_mem_rdata <= ifm_mem[ifm_mem_addr];
        else            ifm_mem_rdata <= IFM_WIDTH'($urandom);
        if (wgt_mem_rd) wgt_mem_rdata <= wgt_mem[wgt_mem_addr];
        else            wgt_mem_rdata <= WEIGHT_WIDTH'($urandom);
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endfunction

    function automatic void model_reset();
        m_st = 0; m_e = 0; m_p = 0; w_i = 0; m_ovr = 0; w_act = 0;
        ovr_vis = 0; busy_vis = 0;
        exp_ifm_rd = 0; exp_wgt_rd = 0; exp_ifm_addr = '0; exp_wgt_addr = '0;
        ifm_q.delete(); wgt_q.delete();
    endfunction

    // One clock of stimulus; the model predicts this cycle's strobes and the data due next cycle.
    task automatic step(input bit st, input bit ir, input bit wr);
        int unsigned ch, r, c, a;
        exp_i_t xi;
        exp_w_t xw;
        @(posedge clk2);
        ovr_vis  = m_ovr;
        busy_vis = (m_st == 1);
        #1;
        start_conv = st; ifm_read = ir; wgt_read = wr;
        exp_ifm_rd = 0; exp_wgt_rd = 0; exp_ifm_addr = '0; exp_wgt_addr = '0;
        if (st) begin
            m_st = 1; m_e = 0; m_p = 0; m_ovr = 0; w_act = 1; w_i = 0;
        end else begin
            if (ir) begin
                if (m_st == 1) begin
                    ch = m_e / (P * P);
                    r  = (m_e / P) % P;
                    c  = m_e % P;
                    if (r >= PAD && r < PAD + IFM_SIZE && c >= PAD && c < PAD + IFM_SIZE) begin
                        a = ch * IFM_SIZE * IFM_SIZE + (r - PAD) * IFM_SIZE + (c - PAD);
                        exp_ifm_rd = 1; exp_ifm_addr = IFM_AW'(a);
                        xi.d = ifm_mem[a];
                    end else begin
                        xi.d = '0;
                    end
                    xi.f = (m_e == FRAME - 1) && (m_p == IFM_PASSES - 1);
                    ifm_q.push_back(xi);
                    if (m_e == FRAME - 1) begin
                        m_e = 0;
                        if (m_p == IFM_PASSES - 1) begin m_p = 0; m_st = 2; end
                        else m_p++;
                    end else begin
                        m_e++;
                    end
                end else begin
                    m_ovr = 1;
                end
            end
            if (wr && w_act) begin
                exp_wgt_rd = 1; exp_wgt_addr = WGT_AW'(w_i);
                xw.d = wgt_mem[w_i];
                xw.f = (w_i == WLEN - 1);
                wgt_q.push_back(xw);
                w_i = (w_i + 1) % WLEN;
            end
        end
    endtask

    task automatic do_reset();
        in_rst = 1;
        @(posedge clk2);
        #1;
        start_conv = 0; ifm_read = 0; wgt_read = 0;
        rst_n = 0;
        #1;
        chk("rst_ifm_valid", 32'(ifm_valid), 0);
        chk("rst_ifm", 32'(ifm), 0);
        chk("rst_wgt_valid", 32'(wgt_valid), 0);
        chk("rst_wgt", 32'(wgt), 0);
        chk("rst_flags", {28'd0, wgt_wrap, ifm_done, busy, overrun}, 0);
        chk("rst_mem_rd", {30'd0, ifm_mem_rd, wgt_mem_rd}, 0);
        @(posedge clk2);
        #1;
        rst_n = 1;
        model_reset();
        in_rst = 0;
    endtask

    // Monitor: compare strobes every cycle and pop expected operands whenever a valid appears.
    always @(negedge clk2) begin
        exp_i_t ie;
        exp_w_t we;
        if (!in_rst) begin
            chk("ifm_mem_rd", 32'(ifm_mem_rd), 32'(exp_ifm_rd));
            if (exp_ifm_rd) chk("ifm_mem_addr", 32'(ifm_mem_addr), 32'(exp_ifm_addr));
            chk("wgt_mem_rd", 32'(wgt_mem_rd), 32'(exp_wgt_rd));
            if (exp_wgt_rd) chk("wgt_mem_addr", 32'(wgt_mem_addr), 32'(exp_wgt_addr));
            chk("overrun", 32'(overrun), 32'(ovr_vis));
            chk("busy", 32'(busy), 32'(busy_vis));
            if (ifm_done) n_done++;
            if (ifm_valid) begin
                n_vec++;
                if (ifm_q.size() == 0) begin
                    n_err++;
                    $display("FAIL ifm_unexpected_valid: got ifm_valid=1 required 0");
                end else begin
                    ie = ifm_q.pop_front();
                    chk("ifm_data", 32'(ifm), 32'(ie.d));
                    chk("ifm_done", 32'(ifm_done), 32'(ie.f));
                end
            end else begin
                chk("ifm_idle_zero", {23'd0, ifm, ifm_done}, 0);
            end
            chk("ifm_latency_ok", 32'(ifm_q.size() <= 1), 1);
            if (wgt_valid) begin
                n_vec++;
                if (wgt_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wgt_unexpected_valid: got wgt_valid=1 required 0");
                end else begin
                    we = wgt_q.pop_front();
                    chk("wgt_data", 32'(wgt), 32'(we.d));
                    chk("wgt_wrap", 32'(wgt_wrap), 32'(we.f));
                end
            end else begin
                chk("wgt_idle_zero", {23'd0, wgt, wgt_wrap}, 0);
            end
            chk("wgt_latency_ok", 32'(wgt_q.size() <= 1), 1);
        end
    end

    initial begin
        int g;
        n_vec = 0; n_err = 0; n_done = 0;
        in_rst = 1; rst_n = 0;
        start_conv = 0; ifm_read = 0; wgt_read = 0;
        foreach (ifm_mem[i]) ifm_mem[i] = IFM_WIDTH'($urandom);
        foreach (wgt_mem[i]) wgt_mem[i] = WEIGHT_WIDTH'($urandom);
        model_reset();
        do_reset();

        // Reads before any start: overrun, no access; start clears it.
        repeat (3) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);

        // Full multi-pass stream with random gaps, weights wrap several times.
        g = 0;
        while (m_st != 2 && g < 20000) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            g++;
        end
        chk("stream_finished_in_budget", 32'(m_st), 2);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        chk("done_pulse_count", 32'(n_done), 1);

        // Restart, then start_conv coinciding with a read at element 500.
        step(1'b1, 1'b0, 1'b1);
        g = 0;
        while (m_e != 500 && g < 5000) begin
            step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            g++;
        end
        chk("reached_elem_500", 32'(m_e), 500);
        step(1'b1, 1'b1, 1'b1);
        repeat (50) step(1'b0, 1'b1, 1'b1);

        // Reset mid-stream, then resume from address 0.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        repeat (200) step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("ifm_queue_drained", 32'(ifm_q.size()), 0);
        chk("wgt_queue_drained", 32'(wgt_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
